// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
// Module      : result_collector
// Description : Round-robin collection of finished Julia pixels into a small
//               FIFO feeding the frame buffer, with frame completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module result_collector #(
    parameter int NUM_WORKERS = 16,
    parameter int COORD_BITS  = 10,
    parameter int CNT_BITS    = 8,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_BITS   = 19
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [NUM_WORKERS-1:0]                 jw_rc_done,
    input  logic [NUM_WORKERS-1:0][COORD_BITS-1:0] jw_rc_x,
    input  logic [NUM_WORKERS-1:0][COORD_BITS-1:0] jw_rc_y,
    input  logic [NUM_WORKERS-1:0][CNT_BITS-1:0]   jw_rc_count,
    output logic [NUM_WORKERS-1:0]                 rc_jw_ack,
    input  logic                                   fb_rc_ready,
    output logic                                   rc_fb_we,
    output logic [ADDR_BITS-1:0]                   rc_fb_addr,
    output logic [CNT_BITS-1:0]                    rc_fb_data,
    output logic                                   frame_done,
    output logic                                   busy,
    output logic                                   rc_err
);

    localparam int c_idx_bits = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam int c_ptr_bits = $clog2(FIFO_DEPTH);

    localparam logic [c_idx_bits:0]   c_num_workers  = (c_idx_bits+1)'(NUM_WORKERS);
    localparam logic [c_idx_bits-1:0] c_last_idx     = c_idx_bits'(NUM_WORKERS - 1);
    localparam logic [COORD_BITS:0]   c_h_res        = (COORD_BITS+1)'(H_RES);
    localparam logic [COORD_BITS:0]   c_v_res        = (COORD_BITS+1)'(V_RES);
    localparam logic [ADDR_BITS-1:0]  c_h_res_addr   = ADDR_BITS'(H_RES);
    localparam logic [ADDR_BITS:0]    c_frame_pixels = (ADDR_BITS+1)'(H_RES * V_RES);
    localparam logic [ADDR_BITS:0]    c_cnt_one      = (ADDR_BITS+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_idx_bits-1:0]   r_ptr;
    logic [ADDR_BITS:0]      r_pix_cnt;
    logic [ADDR_BITS:0]      w_cnt_inc;

    logic [2*NUM_WORKERS-1:0] w_req_dbl;
    logic [NUM_WORKERS-1:0]  w_req_rot;
    logic                    w_grant_vld;
    logic [c_idx_bits-1:0]   w_off;
    logic [c_idx_bits:0]     w_idx_sum;
    logic [c_idx_bits-1:0]   w_grant_idx;
    logic [COORD_BITS-1:0]   w_sel_x;
    logic [COORD_BITS-1:0]   w_sel_y;
    logic [CNT_BITS-1:0]     w_sel_cnt;
    logic [ADDR_BITS-1:0]    w_sel_addr;
    logic                    w_in_range;
    logic                    w_start_frame;

    logic [ADDR_BITS-1:0]    r_addr_mem [FIFO_DEPTH];
    logic [CNT_BITS-1:0]     r_data_mem [FIFO_DEPTH];
    logic [c_ptr_bits:0]     r_wr_ptr;
    logic [c_ptr_bits:0]     r_rd_ptr;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;

    assign w_start_frame = (r_state == S_IDLE) && start;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_bits] != r_rd_ptr[c_ptr_bits]) &&
                     (r_wr_ptr[c_ptr_bits-1:0] == r_rd_ptr[c_ptr_bits-1:0]);

    // Rotate requests so the scan always starts at bit 0, then map back.
    assign w_req_dbl = {jw_rc_done, jw_rc_done} >> r_ptr;
    assign w_req_rot = w_req_dbl[NUM_WORKERS-1:0];

    always_comb begin
        w_grant_vld = 1'b0;
        w_off       = '0;
        for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_grant_vld = 1'b1;
                w_off       = c_idx_bits'(k);
            end
        end
        if (r_state != S_COLLECT || w_full) begin
            w_grant_vld = 1'b0;
        end
        w_idx_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_idx_sum >= c_num_workers) begin
            w_idx_sum = w_idx_sum - c_num_workers;
        end
        w_grant_idx = w_idx_sum[c_idx_bits-1:0];
        rc_jw_ack   = '0;
        if (w_grant_vld) begin
            rc_jw_ack[w_grant_idx] = 1'b1;
        end
    end

    assign w_sel_x    = jw_rc_x[w_grant_idx];
    assign w_sel_y    = jw_rc_y[w_grant_idx];
    assign w_sel_cnt  = jw_rc_count[w_grant_idx];
    assign w_sel_addr = ADDR_BITS'(w_sel_y) * c_h_res_addr + ADDR_BITS'(w_sel_x);
    assign w_in_range = ({1'b0, w_sel_x} < c_h_res) && ({1'b0, w_sel_y} < c_v_res);

    assign w_push    = w_grant_vld && w_in_range;
    assign w_pop     = !w_empty && fb_rc_ready;
    assign w_cnt_inc = r_pix_cnt + c_cnt_one;

    assign rc_fb_we   = !w_empty;
    assign rc_fb_addr = w_empty ? '0 : r_addr_mem[r_rd_ptr[c_ptr_bits-1:0]];
    assign rc_fb_data = w_empty ? '0 : r_data_mem[r_rd_ptr[c_ptr_bits-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr[c_ptr_bits-1:0]] <= w_sel_addr;
            r_data_mem[r_wr_ptr[c_ptr_bits-1:0]] <= w_sel_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ptr     <= '0;
            r_pix_cnt <= '0;
            rc_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_grant_vld) begin
                r_ptr <= (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_start_frame) begin
                r_pix_cnt <= '0;
            end else if (w_pop) begin
                r_pix_cnt <= w_cnt_inc;
            end
            if (w_start_frame) begin
                rc_err <= 1'b0;
            end else if (w_grant_vld && !w_in_range) begin
                rc_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        frame_done  = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_pop && (w_cnt_inc == c_frame_pixels)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_result_collector.sv
`default_nettype none
// Scoreboard bench: a full-size collector and a 4x2 collector share one reset;
// monitors pop expected frame-buffer writes whenever a write transfer is offered.
module tb_result_collector;

    localparam int NW = 16;
    localparam int CB = 10;
    localparam int KB = 8;
    localparam int AB = 19;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic rst;

    logic                   b_start, b_ready, b_we, b_fd, b_busy, b_err;
    logic [NW-1:0]          b_done, b_ack;
    logic [NW-1:0][CB-1:0]  b_x, b_y;
    logic [NW-1:0][KB-1:0]  b_cnt;
    logic [AB-1:0]          b_addr;
    logic [KB-1:0]          b_data;

    logic                   s_start, s_ready, s_we, s_fd, s_busy, s_err;
    logic [NW-1:0]          s_done, s_ack;
    logic [NW-1:0][CB-1:0]  s_x, s_y;
    logic [NW-1:0][KB-1:0]  s_cnt;
    logic [AB-1:0]          s_addr;
    logic [KB-1:0]          s_data;

    result_collector #(
        .NUM_WORKERS(NW), .COORD_BITS(CB), .CNT_BITS(KB), .H_RES(640), .V_RES(480),
        .FIFO_DEPTH(4), .ADDR_BITS(AB)
    ) u_big (
        .clk(tb_clk), .rst(rst), .start(b_start), .jw_rc_done(b_done), .jw_rc_x(b_x),
        .jw_rc_y(b_y), .jw_rc_count(b_cnt), .rc_jw_ack(b_ack), .fb_rc_ready(b_ready),
        .rc_fb_we(b_we), .rc_fb_addr(b_addr), .rc_fb_data(b_data), .frame_done(b_fd),
        .busy(b_busy), .rc_err(b_err)
    );

    result_collector #(
        .NUM_WORKERS(NW), .COORD_BITS(CB), .CNT_BITS(KB), .H_RES(4), .V_RES(2),
        .FIFO_DEPTH(4), .ADDR_BITS(AB)
    ) u_small (
        .clk(tb_clk), .rst(rst), .start(s_start), .jw_rc_done(s_done), .jw_rc_x(s_x),
        .jw_rc_y(s_y), .jw_rc_count(s_cnt), .rc_jw_ack(s_ack), .fb_rc_ready(s_ready),
        .rc_fb_we(s_we), .rc_fb_addr(s_addr), .rc_fb_data(s_data), .frame_done(s_fd),
        .busy(s_busy), .rc_err(s_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [AB+KB-1:0] qb[$];
    logic [AB+KB-1:0] qs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge tb_clk) begin
        logic [AB+KB-1:0] e;
        if (!rst && b_we && b_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL big_unexpected_write: actual addr=0x%0h data=0x%0h required=none", b_addr, b_data);
            end else begin
                e = qb.pop_front();
                chk("big_fb_addr", 32'(b_addr), 32'(e[AB+KB-1:KB]));
                chk("big_fb_data", 32'(b_data), 32'(e[KB-1:0]));
            end
        end
    end

    always @(negedge tb_clk) begin
        logic [AB+KB-1:0] e;
        if (!rst && s_we && s_ready) begin
            if (qs.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL small_unexpected_write: actual addr=0x%0h data=0x%0h required=none", s_addr, s_data);
            end else begin
                e = qs.pop_front();
                chk("small_fb_addr", 32'(s_addr), 32'(e[AB+KB-1:KB]));
                chk("small_fb_data", 32'(s_data), 32'(e[KB-1:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge tb_clk);
    endtask

    task automatic drain_big(input string name);
        for (int i = 0; i < 12 && (qb.size() != 0 || b_we); i++) cyc();
        at_neg();
        chk({name, "_queue_empty"}, 32'(qb.size()), 0);
        chk({name, "_we_idle"}, 32'(b_we), 0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        b_start = 0; b_ready = 0; b_done = '0; b_x = '0; b_y = '0; b_cnt = '0;
        s_start = 0; s_ready = 0; s_done = '0; s_x = '0; s_y = '0; s_cnt = '0;

        // 1: reset state, then IDLE ignores done requests
        cyc(); cyc();
        at_neg();
        chk("rst_ack", 32'(b_ack), 0);
        chk("rst_we", 32'(b_we), 0);
        chk("rst_addr", 32'(b_addr), 0);
        chk("rst_data", 32'(b_data), 0);
        chk("rst_frame_done", 32'(b_fd), 0);
        chk("rst_busy", 32'(b_busy), 0);
        chk("rst_err", 32'(b_err), 0);
        chk("rst_small_busy", 32'(s_busy), 0);
        cyc();
        rst = 1'b0;
        b_done = '1; s_done = '1;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("idle_ack_big", 32'(b_ack), 0);
            chk("idle_ack_small", 32'(s_ack), 0);
            cyc();
        end
        b_done = '0; s_done = '0;

        // 2: single pixel from worker 3
        b_start = 1; cyc(); b_start = 0;
        at_neg();
        chk("collect_busy", 32'(b_busy), 1);
        cyc();
        b_ready = 1;
        b_done[3] = 1; b_x[3] = 10'd5; b_y[3] = 10'd2; b_cnt[3] = 8'h2A;
        qb.push_back({19'd1285, 8'h2A});
        at_neg();
        chk("single_ack", 32'(b_ack), 32'h0008);
        cyc();
        b_done = '0;
        at_neg();
        chk("single_we", 32'(b_we), 1);
        cyc();
        drain_big("single");

        // 3: FIFO fill with frame buffer stalled, then release
        rst = 1; cyc(); cyc(); rst = 0;
        b_start = 1; cyc(); b_start = 0;
        b_ready = 0;
        for (int i = 0; i < NW; i++) begin
            b_x[i] = CB'(i); b_y[i] = 10'd1; b_cnt[i] = KB'(8'h10 + i);
        end
        b_done = '1;
        for (int k = 0; k < 4; k++) begin
            qb.push_back({AB'(640 + k), KB'(8'h10 + k)});
            at_neg();
            chk("fill_ack", 32'(b_ack), 32'(1) << k);
            cyc();
            b_done[k] = 0;
        end
        at_neg();
        chk("full_no_ack", 32'(b_ack), 0);
        chk("full_we", 32'(b_we), 1);
        chk("full_head_addr", 32'(b_addr), 640);
        cyc();
        b_ready = 1;
        at_neg();
        chk("full_no_bypass", 32'(b_ack), 0);
        cyc();
        qb.push_back({19'd644, 8'h14});
        at_neg();
        chk("resume_ack", 32'(b_ack), 32'h0010);
        cyc();
        b_done = '0;
        drain_big("fill");

        // 4: round-robin wrap
        b_x[15] = 10'd15; b_y[15] = 10'd3; b_cnt[15] = 8'h5F;
        b_x[0]  = 10'd0;  b_y[0]  = 10'd3; b_cnt[0]  = 8'h50;
        b_done = 16'h8000;
        qb.push_back({19'd1935, 8'h5F});
        at_neg();
        chk("rr_ack15", 32'(b_ack), 32'h8000);
        cyc();
        b_done = 16'h8001;
        qb.push_back({19'd1920, 8'h50});
        at_neg();
        chk("rr_wrap_ack0", 32'(b_ack), 32'h0001);
        cyc();
        qb.push_back({19'd1935, 8'h5F});
        at_neg();
        chk("rr_then_ack15", 32'(b_ack), 32'h8000);
        cyc();
        b_done = '0;
        drain_big("rr");

        // 5: out-of-range x is acked and dropped
        b_done[2] = 1; b_x[2] = 10'd640; b_y[2] = 10'd0;
        at_neg();
        chk("oor_ack", 32'(b_ack), 32'h0004);
        cyc();
        b_done = '0;
        at_neg();
        chk("oor_no_we", 32'(b_we), 0);
        chk("oor_err", 32'(b_err), 1);
        cyc();

        // 6: complete 4x2 frame, with a dropped out-of-range result first
        s_ready = 1;
        s_start = 1; cyc(); s_start = 0;
        s_done[1] = 1; s_x[1] = 10'd4; s_y[1] = 10'd0;
        at_neg();
        chk("small_oor_ack", 32'(s_ack), 32'h0002);
        cyc();
        s_done = '0;
        for (int p = 0; p < 8; p++) begin
            int w;
            w = (2 + p) % NW;
            s_done = '0;
            s_done[w] = 1; s_x[w] = CB'(p % 4); s_y[w] = CB'(p / 4); s_cnt[w] = KB'(8'h80 + p);
            qs.push_back({AB'(p), KB'(8'h80 + p)});
            at_neg();
            chk("frame_ack", 32'(s_ack), 32'(1) << w);
            chk("frame_not_done_early", 32'(s_fd), 0);
            cyc();
        end
        s_done = '0;
        at_neg();
        chk("last_write_we", 32'(s_we), 1);
        chk("last_write_no_done", 32'(s_fd), 0);
        cyc();
        at_neg();
        chk("frame_done_pulse", 32'(s_fd), 1);
        chk("frame_done_busy", 32'(s_busy), 1);
        chk("frame_queue_empty", 32'(qs.size()), 0);
        cyc();
        at_neg();
        chk("frame_done_clear", 32'(s_fd), 0);
        chk("frame_idle_busy", 32'(s_busy), 0);
        chk("err_sticky", 32'(s_err), 1);
        cyc();

        // 6b: repeat frame, reset after three writes
        s_start = 1; cyc(); s_start = 0;
        at_neg();
        chk("restart_err_clear", 32'(s_err), 0);
        chk("restart_busy", 32'(s_busy), 1);
        cyc();
        for (int p = 0; p < 4; p++) begin
            int w;
            w = (10 + p) % NW;
            s_done = '0;
            s_done[w] = 1; s_x[w] = CB'(p % 4); s_y[w] = CB'(p / 4); s_cnt[w] = KB'(8'h90 + p);
            qs.push_back({AB'(p), KB'(8'h90 + p)});
            at_neg();
            chk("abort_ack", 32'(s_ack), 32'(1) << w);
            cyc();
        end
        chk("abort_writes_seen", 32'(qs.size()), 1);
        s_done = '0;
        s_done[14] = 1;
        rst = 1;
        qs.delete();
        qb.delete();
        cyc();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("abort_fifo_empty", 32'(s_we), 0);
            chk("abort_idle", 32'(s_busy), 0);
            chk("abort_no_done", 32'(s_fd), 0);
            chk("abort_no_ack", 32'(s_ack), 0);
            cyc();
        end
        chk("big_queue_final", 32'(qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
